bird_wave_scheduler: RTL and testbench
======================================

BIRD_WAVE_SCHEDULER -- requirements
Module: bird_wave_scheduler

Interface
REQ-001 Parameter NUM_BIRDS, default 4: number of bird slots controlled.
REQ-002 Parameter SPAWN_GAP, default 60: frames between consecutive slot deploys within a wave.
REQ-003 Parameter INTER_FRAMES, default 90: frames of pause between waves.
REQ-004 Parameter MAX_WAVE, default 7: index of the final wave; waves run 0..MAX_WAVE.
REQ-005 Clocking: one clock; reset is synchronous and active-low.
REQ-006 Port clk, input, 1: system clock.
REQ-007 Port resetN, input, 1: synchronous active-low reset.
REQ-008 Port startOfFrame, input, 1: one-clk pulse per frame.
REQ-009 Port start_game, input, 1: one-clk pulse; starts or restarts a game.
REQ-010 Port alive, input, NUM_BIRDS: per-slot alive flag from the bird instances.
REQ-011 Port poop_req, input, NUM_BIRDS: per-slot bomb request level from the birds.
REQ-012 Port bomb_busy, input, 1: the shared bomb object is in flight.
REQ-013 Port deploy, output, NUM_BIRDS: per-slot deploy strobe.
REQ-014 Port starting_life, output, 4: life value for deploying birds.
REQ-015 Port speed, output, 2: speed value for all birds.
REQ-016 Port bomb_grant, output, NUM_BIRDS: one-hot, one-clk grant of the shared bomb.
REQ-017 Port wave, output, 3: current wave index.
REQ-018 Port game_won, output, 1: high after the final wave is cleared.

Function
REQ-019 The FSM SHALL have the states IDLE, SPAWN, WAIT_CLEAR, INTERMISSION and WON.
REQ-020 start_game SHALL, in any state, enter SPAWN on the next clk: wave=0, slot=0, gap counter=0, deploy=0, pending=0.
REQ-021 In SPAWN, at a startOfFrame cycle with gap counter 0: set deploy[slot], reload gap counter to SPAWN_GAP, and advance slot.
REQ-022 In SPAWN, at any other startOfFrame cycle, the gap counter SHALL decrement, saturating at 0.
REQ-023 deploy[i] SHALL stay high through the next startOfFrame cycle inclusive, then clear, so each bird samples it exactly once.
REQ-024 After deploy[NUM_BIRDS-1] is set, the FSM SHALL enter WAIT_CLEAR.
REQ-025 In WAIT_CLEAR, at a startOfFrame cycle with alive==0 and deploy==0: if wave==MAX_WAVE go to WON, else go to INTERMISSION with counter=INTER_FRAMES.
REQ-026 In INTERMISSION, the counter SHALL decrement per startOfFrame; on the frame it is 0, wave increments and the FSM enters SPAWN with slot=0 and gap=0.
REQ-027 In WON, game_won=1 and all deploy/grant outputs SHALL be 0; WON exits only on start_game or reset.
REQ-028 starting_life SHALL equal 1+wave, registered (range 1..8).
REQ-029 speed SHALL equal min(wave>>1, 3), registered.
REQ-030 Bomb request detection: pending[i] SHALL set on a rising edge of poop_req[i] (previous-cycle register).
REQ-031 pending[i] SHALL clear when granted or when alive[i]==0; a set and clear in the same cycle resolve to set.
REQ-032 Arbitration: when bomb_busy==0, no grant in the previous cycle, and pending!=0, assert bomb_grant for exactly one clk to the first pending slot at or after rr_ptr, searching round-robin with wrap from NUM_BIRDS-1 to 0.
REQ-033 After a grant to slot i, rr_ptr SHALL become (i+1) mod NUM_BIRDS.
REQ-034 The arbiter SHALL operate in every state except IDLE and WON; in IDLE and WON, pending SHALL be held at 0.

Reset
REQ-035 With resetN=0 at a clk edge: state=IDLE, wave=0, slot=0, counters=0, rr_ptr=0, pending=0, deploy=0, bomb_grant=0, game_won=0, starting_life=1, speed=0.
REQ-036 Reset mid-wave SHALL drop all pending requests and any deploy strobe in the same edge.

Verification
REQ-037 Reset, then start_game, then 4 frames -> deploy[0] high through frame 1 only; deploy[1] on frame 61; starting_life=1, speed=0.
REQ-038 All 4 deployed, alive forced to 0 -> INTERMISSION; after 91 frames wave=1, starting_life=2; wave=2 -> speed=1.
REQ-039 poop_req rising on slots 1 and 3 in the same cycle, rr_ptr=2 -> grant 0b1000, then after one idle cycle grant 0b0010.
REQ-040 bomb_busy=1 while a request is pending -> no grant; bomb_busy falls -> grant next clk; alive drops before the grant -> no grant.
REQ-041 Clear wave 7 -> game_won=1 and deploy stays 0; start_game -> game_won=0, wave=0, SPAWN.
REQ-042 resetN=0 on a cycle with deploy[2] high and pending=0b0101 -> all outputs at reset values on the next clk.

Source files
------------

// File: rtl/bird_wave_scheduler.sv
// rtl/bird_wave_scheduler.sv - wave/spawn sequencer with round-robin arbitration of the shared bomb
//
// Ports:
//   clk            : system clock
//   resetN         : synchronous active-low reset
//   startOfFrame   : one-clk pulse per video frame
//   start_game     : one-clk pulse, starts or restarts a game at wave 0
//   alive          : per-slot alive flag from the bird instances
//   poop_req       : per-slot bomb request level from the birds
//   bomb_busy      : shared bomb object is in flight
//   deploy         : per-slot deploy strobe, held until the next frame pulse inclusive
//   starting_life  : life value for deploying birds (1 + wave)
//   speed          : speed value for all birds (min(wave/2, 3))
//   bomb_grant     : one-hot, one-clk grant of the shared bomb
//   wave           : current wave index
//   game_won       : high once the final wave has been cleared
module bird_wave_scheduler #(
    parameter int NUM_BIRDS    = 4,
    parameter int SPAWN_GAP    = 60,
    parameter int INTER_FRAMES = 90,
    parameter int MAX_WAVE     = 7
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 startOfFrame,
    input  logic                 start_game,
    input  logic [NUM_BIRDS-1:0] alive,
    input  logic [NUM_BIRDS-1:0] poop_req,
    input  logic                 bomb_busy,
    output logic [NUM_BIRDS-1:0] deploy,
    output logic [3:0]           starting_life,
    output logic [1:0]           speed,
    output logic [NUM_BIRDS-1:0] bomb_grant,
    output logic [2:0]           wave,
    output logic                 game_won
);

    localparam int SW = (NUM_BIRDS > 1) ? $clog2(NUM_BIRDS) : 1;
    localparam int GW = (SPAWN_GAP > 0) ? $clog2(SPAWN_GAP + 1) : 1;
    localparam int IW = (INTER_FRAMES > 0) ? $clog2(INTER_FRAMES + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SPAWN,
        S_WAIT_CLEAR,
        S_INTERMISSION,
        S_WON
    } state_t;

    state_t               state_q, state_d;
    logic [2:0]           wave_q, wave_d;
    logic [SW-1:0]        slot_q, slot_d;
    logic [SW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]        gap_q, gap_d;
    logic [IW-1:0]        inter_q, inter_d;
    logic [NUM_BIRDS-1:0] deploy_q, deploy_d;
    logic [NUM_BIRDS-1:0] grant_q, grant_d;
    logic [NUM_BIRDS-1:0] pending_q, pending_d;
    logic [NUM_BIRDS-1:0] poop_q;
    logic [3:0]           life_q, life_d;
    logic [1:0]           speed_q, speed_d;

    // The arbiter only runs while a game is actually in progress.
    function automatic logic is_active(state_t s);
        return (s == S_SPAWN) || (s == S_WAIT_CLEAR) || (s == S_INTERMISSION);
    endfunction

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q   <= S_IDLE;
            wave_q    <= '0;
            slot_q    <= '0;
            rr_ptr_q  <= '0;
            gap_q     <= '0;
            inter_q   <= '0;
            deploy_q  <= '0;
            grant_q   <= '0;
            pending_q <= '0;
            poop_q    <= '0;
            life_q    <= 4'd1;
            speed_q   <= '0;
        end else begin
            state_q   <= state_d;
            wave_q    <= wave_d;
            slot_q    <= slot_d;
            rr_ptr_q  <= rr_ptr_d;
            gap_q     <= gap_d;
            inter_q   <= inter_d;
            deploy_q  <= deploy_d;
            grant_q   <= grant_d;
            pending_q <= pending_d;
            poop_q    <= poop_req;
            life_q    <= life_d;
            speed_q   <= speed_d;
        end
    end

    always_comb begin : next_state
        state_d  = state_q;
        wave_d   = wave_q;
        slot_d   = slot_q;
        gap_d    = gap_q;
        inter_d  = inter_q;
        // A strobe set on one frame pulse is sampled by the bird on the next one, then dropped.
        deploy_d = startOfFrame ? '0 : deploy_q;

        unique case (state_q)
            S_SPAWN: begin
                if (startOfFrame) begin
                    if (gap_q == '0) begin
                        deploy_d[slot_q] = 1'b1;
                        gap_d            = GW'(SPAWN_GAP);
                        slot_d           = slot_q + 1'b1;
                        if (slot_q == SW'(NUM_BIRDS - 1)) begin
                            state_d = S_WAIT_CLEAR;
                        end
                    end else begin
                        gap_d = gap_q - 1'b1;
                    end
                end
            end
            S_WAIT_CLEAR: begin
                // deploy_q must be empty too, otherwise the last bird has not yet seen its strobe.
                if (startOfFrame && (alive == '0) && (deploy_q == '0)) begin
                    if (wave_q == 3'(MAX_WAVE)) begin
                        state_d = S_WON;
                    end else begin
                        state_d = S_INTERMISSION;
                        inter_d = IW'(INTER_FRAMES);
                    end
                end
            end
            S_INTERMISSION: begin
                if (startOfFrame) begin
                    if (inter_q == '0) begin
                        wave_d  = wave_q + 3'd1;
                        state_d = S_SPAWN;
                        slot_d  = '0;
                        gap_d   = '0;
                    end else begin
                        inter_d = inter_q - 1'b1;
                    end
                end
            end
            S_IDLE, S_WON: begin
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (start_game) begin
            state_d  = S_SPAWN;
            wave_d   = '0;
            slot_d   = '0;
            gap_d    = '0;
            inter_d  = '0;
            deploy_d = '0;
        end
        if (state_d == S_WON) begin
            deploy_d = '0;
        end

        // Registered from the next wave so they always track the wave output.
        life_d  = {1'b0, wave_d} + 4'd1;
        speed_d = wave_d[2:1];
    end

    always_comb begin : arbiter
        logic [NUM_BIRDS-1:0] rise;
        logic [NUM_BIRDS-1:0] eligible;
        logic [SW-1:0]        sel;
        logic                 arb_en;
        logic                 found;
        int                   idx;

        rise     = poop_req & ~poop_q;
        // A slot that died is never granted, even if its clear lands on this same edge.
        eligible = pending_q & alive;
        arb_en   = is_active(state_q) && is_active(state_d) && !start_game;
        grant_d  = '0;
        rr_ptr_d = rr_ptr_q;
        found    = 1'b0;
        idx      = 0;
        sel      = '0;

        // grant_q check forces an idle cycle after each grant so bomb_busy can rise.
        if (arb_en && !bomb_busy && (grant_q == '0)) begin
            for (int k = 0; k < NUM_BIRDS; k++) begin
                idx = int'(rr_ptr_q) + k;
                if (idx >= NUM_BIRDS) begin
                    idx = idx - NUM_BIRDS;
                end
                sel = SW'(idx);
                if (!found && eligible[sel]) begin
                    found        = 1'b1;
                    grant_d[sel] = 1'b1;
                    rr_ptr_d     = (sel == SW'(NUM_BIRDS - 1)) ? '0 : sel + 1'b1;
                end
            end
        end

        // A new rising edge wins over a grant/death clear in the same cycle.
        pending_d = arb_en ? ((pending_q & alive & ~grant_d) | rise) : '0;
    end

    always_comb begin : outputs
        deploy        = deploy_q;
        bomb_grant    = grant_q;
        wave          = wave_q;
        starting_life = life_q;
        speed         = speed_q;
        game_won      = (state_q == S_WON);
    end

endmodule

// File: tb/tb_bird_wave_scheduler.sv
// tb/tb_bird_wave_scheduler.sv - self-checking bench for bird_wave_scheduler
module tb_bird_wave_scheduler;

    localparam int N     = 4;
    localparam int GAP   = 60;
    localparam int INTER = 90;
    localparam int MAXW  = 7;

    localparam int P_IDLE  = 0;
    localparam int P_SPAWN = 1;
    localparam int P_WAIT  = 2;
    localparam int P_INTER = 3;
    localparam int P_WON   = 4;

    logic         clk          = 1'b0;
    logic         resetN       = 1'b0;
    logic         startOfFrame = 1'b0;
    logic         start_game   = 1'b0;
    logic         bomb_busy    = 1'b0;
    logic [N-1:0] alive        = '0;
    logic [N-1:0] poop_req     = '0;

    logic [N-1:0] deploy;
    logic [N-1:0] bomb_grant;
    logic [3:0]   starting_life;
    logic [1:0]   speed;
    logic [2:0]   wave;
    logic         game_won;

    int n_checks = 0;
    int n_fail   = 0;
    int cnt      = 0;
    bit clear_mode = 1'b0;

    // reference model state
    int           m_phase, m_wave, m_spawn_f, m_inter_f, m_rr;
    logic [N-1:0] m_deploy, m_grant, m_pending, m_poop_prev;

    bird_wave_scheduler #(
        .NUM_BIRDS   (N),
        .SPAWN_GAP   (GAP),
        .INTER_FRAMES(INTER),
        .MAX_WAVE    (MAXW)
    ) dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .start_game   (start_game),
        .alive        (alive),
        .poop_req     (poop_req),
        .bomb_busy    (bomb_busy),
        .deploy       (deploy),
        .starting_life(starting_life),
        .speed        (speed),
        .bomb_grant   (bomb_grant),
        .wave         (wave),
        .game_won     (game_won)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit in_game(input int p);
        return (p == P_SPAWN) || (p == P_WAIT) || (p == P_INTER);
    endfunction

    // Slot k deploys on spawn frame k*(GAP+1); wave advances on intermission frame INTER.
    task automatic model_step();
        logic [N-1:0] rise, dep, g, elig;
        int           nph, nwave, s;
        bit           act, found;
        if (!resetN) begin
            m_phase = P_IDLE; m_wave = 0; m_spawn_f = 0; m_inter_f = 0; m_rr = 0;
            m_deploy = '0; m_grant = '0; m_pending = '0; m_poop_prev = '0;
        end else begin
            rise  = poop_req & ~m_poop_prev;
            dep   = startOfFrame ? '0 : m_deploy;
            nph   = m_phase;
            nwave = m_wave;
            if (startOfFrame) begin
                if (m_phase == P_SPAWN) begin
                    if (m_spawn_f % (GAP + 1) == 0) begin
                        s   = m_spawn_f / (GAP + 1);
                        dep = dep | N'(1 << s);
                        if (s == N - 1) nph = P_WAIT;
                    end
                    m_spawn_f++;
                end else if (m_phase == P_WAIT) begin
                    if (alive == '0 && m_deploy == '0) begin
                        if (m_wave == MAXW) nph = P_WON;
                        else begin nph = P_INTER; m_inter_f = 0; end
                    end
                end else if (m_phase == P_INTER) begin
                    if (m_inter_f == INTER) begin
                        nwave = m_wave + 1; nph = P_SPAWN; m_spawn_f = 0;
                    end else begin
                        m_inter_f++;
                    end
                end
            end
            if (start_game) begin
                nph = P_SPAWN; nwave = 0; m_spawn_f = 0; dep = '0;
            end
            if (nph == P_WON) dep = '0;
            act   = in_game(m_phase) && in_game(nph) && !start_game;
            g     = '0;
            found = 1'b0;
            elig  = m_pending & alive;
            if (act && !bomb_busy && m_grant == '0) begin
                for (int k = 0; k < N; k++) begin
                    s = (m_rr + k) % N;
                    if (!found && (((32'(elig) >> s) & 1) == 1)) begin
                        found = 1'b1;
                        g     = N'(1 << s);
                        m_rr  = (s + 1) % N;
                    end
                end
            end
            m_pending   = act ? ((m_pending & alive & ~g) | rise) : '0;
            m_grant     = g;
            m_deploy    = dep;
            m_phase     = nph;
            m_wave      = nwave;
            m_poop_prev = poop_req;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_val("deploy", 32'(deploy), 32'(m_deploy));
        check_val("bomb_grant", 32'(bomb_grant), 32'(m_grant));
        check_val("wave", 32'(wave), m_wave);
        check_val("starting_life", 32'(starting_life), m_wave + 1);
        check_val("speed", 32'(speed), (m_wave / 2 > 3) ? 3 : m_wave / 2);
        check_val("game_won", 32'(game_won), (m_phase == P_WON) ? 1 : 0);
    endtask

    task automatic run_frame();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        repeat (3) tick();
    endtask

    task automatic pulse_start();
        start_game = 1'b1;
        tick();
        start_game = 1'b0;
    endtask

    task automatic rand_inputs();
        startOfFrame = ($urandom_range(3) == 0);
        start_game   = ($urandom_range(1499) == 0);
        resetN       = ($urandom_range(2999) != 0);
        bomb_busy    = ($urandom_range(2) == 0);
        if ($urandom_range(3) == 0) poop_req = poop_req ^ N'(1 << $urandom_range(N - 1));
        if ($urandom_range(199) == 0) clear_mode = !clear_mode;
        if (clear_mode) alive = '0;
        else if ($urandom_range(7) == 0) alive = alive ^ N'(1 << $urandom_range(N - 1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time 0x%0h expected below 0x%0h", $time, 1_000_000);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // reset state
        resetN = 1'b0;
        poop_req = 4'b1111; alive = 4'b1111; start_game = 1'b1;
        repeat (3) tick();
        check_val("rst_deploy", 32'(deploy), 0);
        check_val("rst_grant", 32'(bomb_grant), 0);
        check_val("rst_life", 32'(starting_life), 1);
        check_val("rst_speed", 32'(speed), 0);
        check_val("rst_won", 32'(game_won), 0);
        start_game = 1'b0; poop_req = '0; alive = '0;
        resetN = 1'b1;
        tick();

        // spawn timing and wave progression with default gaps
        pulse_start();
        run_frame();
        check_val("f0_deploy", 32'(deploy), 32'h1);
        check_val("f0_life", 32'(starting_life), 1);
        check_val("f0_speed", 32'(speed), 0);
        run_frame();
        check_val("f1_deploy", 32'(deploy), 0);
        repeat (59) run_frame();
        check_val("f60_deploy", 32'(deploy), 0);
        run_frame();
        check_val("f61_deploy", 32'(deploy), 32'h2);
        repeat (122) run_frame();
        check_val("f183_deploy", 32'(deploy), 32'h8);
        repeat (2) run_frame();
        repeat (90) run_frame();
        check_val("inter_wave0", 32'(wave), 0);
        run_frame();
        check_val("w1_wave", 32'(wave), 1);
        check_val("w1_life", 32'(starting_life), 2);
        cnt = 0;
        while (wave != 3'd2 && cnt < 400) begin run_frame(); cnt++; end
        check_val("w2_reached", 32'(wave), 2);
        check_val("w2_speed", 32'(speed), 1);
        check_val("w2_life", 32'(starting_life), 3);

        // round-robin arbitration
        alive = 4'b1111; bomb_busy = 1'b0;
        poop_req = 4'b0010; tick(); tick();
        check_val("g_prime", 32'(bomb_grant), 32'h2);
        poop_req = '0; tick(); tick();
        poop_req = 4'b1010; tick(); tick();
        check_val("rr_first", 32'(bomb_grant), 32'h8);
        tick();
        check_val("rr_idle", 32'(bomb_grant), 0);
        tick();
        check_val("rr_second", 32'(bomb_grant), 32'h2);

        // bomb_busy holds off, dead slot is never granted
        poop_req = '0; tick(); tick();
        bomb_busy = 1'b1; poop_req = 4'b0100; tick(); tick(); tick();
        check_val("busy_hold", 32'(bomb_grant), 0);
        bomb_busy = 1'b0; tick();
        check_val("busy_release", 32'(bomb_grant), 32'h4);
        poop_req = '0; tick(); tick();
        bomb_busy = 1'b1; poop_req = 4'b0001; tick();
        alive = 4'b1110; tick();
        bomb_busy = 1'b0; tick();
        check_val("dead_nogrant", 32'(bomb_grant), 0);
        tick();
        check_val("dead_nogrant2", 32'(bomb_grant), 0);

        // full game to the win state
        alive = '0; poop_req = '0; bomb_busy = 1'b0;
        pulse_start();
        cnt = 0;
        while (!game_won && cnt < 2600) begin run_frame(); cnt++; end
        check_val("won", 32'(game_won), 1);
        check_val("won_wave", 32'(wave), 7);
        check_val("won_deploy", 32'(deploy), 0);
        alive = 4'b1111; poop_req = 4'b1111;
        repeat (3) run_frame();
        check_val("won_nogrant", 32'(bomb_grant), 0);
        check_val("won_hold", 32'(game_won), 1);
        check_val("won_deploy2", 32'(deploy), 0);
        pulse_start();
        check_val("restart_won", 32'(game_won), 0);
        check_val("restart_wave", 32'(wave), 0);
        run_frame();
        check_val("restart_spawn", 32'(deploy), 32'h1);
        poop_req = '0;

        // reset in the middle of a wave
        alive = 4'b1111; bomb_busy = 1'b1;
        pulse_start();
        repeat (123) run_frame();
        check_val("pre_rst_deploy", 32'(deploy), 32'h4);
        poop_req = 4'b0101; tick();
        resetN = 1'b0; tick();
        check_val("mid_rst_deploy", 32'(deploy), 0);
        check_val("mid_rst_grant", 32'(bomb_grant), 0);
        check_val("mid_rst_life", 32'(starting_life), 1);
        check_val("mid_rst_speed", 32'(speed), 0);
        check_val("mid_rst_won", 32'(game_won), 0);
        resetN = 1'b1; bomb_busy = 1'b0; tick(); tick();
        check_val("rst_pending_dropped", 32'(bomb_grant), 0);

        // randomized traffic
        poop_req = '0; alive = '0;
        pulse_start();
        for (int i = 0; i < 20000; i++) begin
            rand_inputs();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
